// File: rtl/execute_stage.sv
// Execute stage: evaluates the ARM condition against the NZCV register, runs the
// operand2 shifter and the ALU, and forms branch targets, link values and memory
// addresses. Results are held in one registered output slot with valid/ready flow.
//
// Ports
//   clk, nreset             clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake (in_ready = !out_valid || out_ready)
//   pc .. branch_link       decoded instruction fields and register read values
//   out_valid / out_ready   downstream handshake for the output slot
//   wb_en, wb_reg, wb_value register writeback request
//   mem_en, mem_is_load,
//   mem_addr, mem_store_data memory access request
//   branch_taken,
//   branch_target           fetch redirect
//   undef                   undefined instruction with passing condition
//   flags                   current NZCV register ({N,Z,C,V})
module execute_stage #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned PC_AHEAD  = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] pc,
  input  logic [3:0]           condition,
  input  logic [1:0]           format,
  input  logic [3:0]           opcode,
  input  logic                 set_flags,
  input  logic                 is_immediate,
  input  logic [3:0]           Rd,
  input  logic [BIT_WIDTH-1:0] Rn_value,
  input  logic [BIT_WIDTH-1:0] Rm_value,
  input  logic [11:0]          operand,
  input  logic                 is_load,
  input  logic [11:0]          mem_offset,
  input  logic [23:0]          branch_offset,
  input  logic                 branch_link,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 wb_en,
  output logic [3:0]           wb_reg,
  output logic [BIT_WIDTH-1:0] wb_value,
  output logic                 mem_en,
  output logic                 mem_is_load,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_store_data,
  output logic                 branch_taken,
  output logic [BIT_WIDTH-1:0] branch_target,
  output logic                 undef,
  output logic [3:0]           flags
);

  localparam int unsigned W = BIT_WIDTH;

  localparam logic [1:0] FMT_DP  = 2'b00;
  localparam logic [1:0] FMT_MEM = 2'b01;
  localparam logic [1:0] FMT_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  logic n_flag, z_flag, c_flag, v_flag;
  assign {n_flag, z_flag, c_flag, v_flag} = flags;

  // Bit 4 selects register-specified shifts, which decode never sends here.
  logic unused_ok;
  assign unused_ok = operand[4];

  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Condition check against the registered flags; 15 never passes.
  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (condition)
      4'h0:    cond_pass = z_flag;
      4'h1:    cond_pass = !z_flag;
      4'h2:    cond_pass = c_flag;
      4'h3:    cond_pass = !c_flag;
      4'h4:    cond_pass = n_flag;
      4'h5:    cond_pass = !n_flag;
      4'h6:    cond_pass = v_flag;
      4'h7:    cond_pass = !v_flag;
      4'h8:    cond_pass = c_flag && !z_flag;
      4'h9:    cond_pass = !c_flag || z_flag;
      4'hA:    cond_pass = (n_flag == v_flag);
      4'hB:    cond_pass = (n_flag != v_flag);
      4'hC:    cond_pass = !z_flag && (n_flag == v_flag);
      4'hD:    cond_pass = z_flag || (n_flag != v_flag);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Operand2 shifter with carry-out.
  logic [4:0]     shamt;
  logic [W-1:0]   op2;
  logic           shc;
  logic [2*W-1:0] rot_dbl;
  assign shamt = operand[11:7];

  always_comb begin
    op2     = '0;
    shc     = c_flag;
    rot_dbl = '0;
    if (is_immediate) begin
      rot_dbl = {W'(operand[7:0]), W'(operand[7:0])} >> {operand[11:8], 1'b0};
      op2     = rot_dbl[W-1:0];
      if (operand[11:8] != 4'd0) shc = op2[W-1];
    end else begin
      case (operand[6:5])
        2'b00: begin
          op2 = Rm_value << shamt;
          if (shamt != 5'd0) shc = Rm_value[5'(W - shamt)];
        end
        2'b01: begin
          if (shamt == 5'd0) begin
            op2 = '0;
            shc = Rm_value[W-1];
          end else begin
            op2 = Rm_value >> shamt;
            shc = Rm_value[shamt - 5'd1];
          end
        end
        2'b10: begin
          if (shamt == 5'd0) begin
            op2 = {W{Rm_value[W-1]}};
            shc = Rm_value[W-1];
          end else begin
            op2 = $unsigned($signed(Rm_value) >>> shamt);
            shc = Rm_value[shamt - 5'd1];
          end
        end
        default: begin
          if (shamt == 5'd0) begin
            op2 = {c_flag, Rm_value[W-1:1]};
            shc = Rm_value[0];
          end else begin
            rot_dbl = {Rm_value, Rm_value} >> shamt;
            op2     = rot_dbl[W-1:0];
            shc     = Rm_value[shamt - 5'd1];
          end
        end
      endcase
    end
  end

  // Adder operand selection: subtracts are a + ~b + carry-in.
  logic [W-1:0] add_a, add_b;
  logic         add_cin;
  logic [W:0]   sum;
  logic         add_v;

  always_comb begin
    add_a   = Rn_value;
    add_b   = op2;
    add_cin = 1'b0;
    case (opcode)
      OP_SUB, OP_CMP: begin add_b = ~op2;      add_cin = 1'b1;   end
      OP_RSB:         begin add_a = ~Rn_value; add_cin = 1'b1;   end
      OP_ADC:         begin                    add_cin = c_flag; end
      OP_SBC:         begin add_b = ~op2;      add_cin = c_flag; end
      OP_RSC:         begin add_a = ~Rn_value; add_cin = c_flag; end
      default:        begin end
    endcase
  end

  assign sum   = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_v = (add_a[W-1] == add_b[W-1]) && (sum[W-1] != add_a[W-1]);

  // ALU result and resulting carry/overflow.
  logic [W-1:0] alu_res;
  logic         res_c, res_v;
  always_comb begin
    alu_res = sum[W-1:0];
    res_c   = sum[W];
    res_v   = add_v;
    case (opcode)
      OP_AND, OP_TST: begin alu_res = Rn_value & op2;  res_c = shc; res_v = v_flag; end
      OP_EOR, OP_TEQ: begin alu_res = Rn_value ^ op2;  res_c = shc; res_v = v_flag; end
      OP_ORR:         begin alu_res = Rn_value | op2;  res_c = shc; res_v = v_flag; end
      OP_MOV:         begin alu_res = op2;             res_c = shc; res_v = v_flag; end
      OP_BIC:         begin alu_res = Rn_value & ~op2; res_c = shc; res_v = v_flag; end
      OP_MVN:         begin alu_res = ~op2;            res_c = shc; res_v = v_flag; end
      default:        begin end
    endcase
  end

  logic test_op;
  assign test_op = (opcode[3:2] == 2'b10);

  // Next slot contents; enables are gated by the condition.
  logic         nx_wb_en, nx_mem_en, nx_branch, nx_undef;
  logic [3:0]   nx_wb_reg, nx_flags;
  logic [W-1:0] nx_wb_value, nx_mem_addr, nx_store, nx_target;

  always_comb begin
    nx_wb_en    = 1'b0;
    nx_mem_en   = 1'b0;
    nx_branch   = 1'b0;
    nx_undef    = 1'b0;
    nx_wb_reg   = Rd;
    nx_wb_value = alu_res;
    nx_mem_addr = Rn_value + W'(mem_offset);
    nx_store    = is_load ? '0 : Rm_value;
    nx_target   = pc + W'(PC_AHEAD) + {{6{branch_offset[23]}}, branch_offset, 2'b00};
    nx_flags    = flags;
    if (cond_pass) begin
      case (format)
        FMT_DP: begin
          nx_wb_en = !test_op;
          if (test_op || set_flags)
            nx_flags = {alu_res[W-1], (alu_res == '0), res_c, res_v};
        end
        FMT_MEM: nx_mem_en = 1'b1;
        FMT_BR: begin
          nx_branch = 1'b1;
          if (branch_link) begin
            nx_wb_en    = 1'b1;
            nx_wb_reg   = 4'd14;
            nx_wb_value = pc + W'(4);
          end
        end
        default: nx_undef = 1'b1;
      endcase
    end
  end

  // Output slot and flags register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid      <= 1'b0;
      wb_en          <= 1'b0;
      wb_reg         <= '0;
      wb_value       <= '0;
      mem_en         <= 1'b0;
      mem_is_load    <= 1'b0;
      mem_addr       <= '0;
      mem_store_data <= '0;
      branch_taken   <= 1'b0;
      branch_target  <= '0;
      undef          <= 1'b0;
      flags          <= '0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      wb_en          <= nx_wb_en;
      wb_reg         <= nx_wb_reg;
      wb_value       <= nx_wb_value;
      mem_en         <= nx_mem_en;
      mem_is_load    <= is_load;
      mem_addr       <= nx_mem_addr;
      mem_store_data <= nx_store;
      branch_taken   <= nx_branch;
      branch_target  <= nx_target;
      undef          <= nx_undef;
      flags          <= nx_flags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: expected slots are queued when an instruction is
// accepted and compared when the DUT hands the slot downstream.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [3:0]  condition;
  logic [1:0]  format;
  logic [3:0]  opcode;
  logic        set_flags;
  logic        is_immediate;
  logic [3:0]  Rd;
  logic [31:0] Rn_value;
  logic [31:0] Rm_value;
  logic [11:0] operand;
  logic        is_load;
  logic [11:0] mem_offset;
  logic [23:0] branch_offset;
  logic        branch_link;
  logic        out_valid;
  logic        out_ready;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_value;
  logic        mem_en;
  logic        mem_is_load;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        undef;
  logic [3:0]  flags;

  execute_stage #(.BIT_WIDTH(32), .PC_AHEAD(8)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .condition(condition), .format(format), .opcode(opcode),
    .set_flags(set_flags), .is_immediate(is_immediate), .Rd(Rd),
    .Rn_value(Rn_value), .Rm_value(Rm_value), .operand(operand),
    .is_load(is_load), .mem_offset(mem_offset), .branch_offset(branch_offset),
    .branch_link(branch_link), .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_value(wb_value), .mem_en(mem_en),
    .mem_is_load(mem_is_load), .mem_addr(mem_addr),
    .mem_store_data(mem_store_data), .branch_taken(branch_taken),
    .branch_target(branch_target), .undef(undef), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cond;
    logic [1:0]  fmt;
    logic [3:0]  opc;
    logic        s;
    logic        imm;
    logic [3:0]  rd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] operand;
    logic        ld;
    logic [11:0] moff;
    logic [23:0] boff;
    logic        bl;
  } instr_t;

  typedef struct packed {
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [31:0] wb_value;
    logic        mem_en;
    logic        mem_is_load;
    logic [31:0] mem_addr;
    logic [31:0] store;
    logic        taken;
    logic [31:0] target;
    logic        undef;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_ready = 1'b0;
  int   held_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t blank();
    instr_t i;
    i = '0;
    i.cond = 4'hE;
    return i;
  endfunction

  function automatic instr_t dp(input logic [3:0] cond, input logic [3:0] opc, input logic s,
                                input logic imm, input logic [3:0] rd, input logic [31:0] rn,
                                input logic [31:0] rm, input logic [11:0] op);
    instr_t i;
    i = blank();
    i.cond = cond; i.opc = opc; i.s = s; i.imm = imm; i.rd = rd;
    i.rn = rn; i.rm = rm; i.operand = op;
    return i;
  endfunction

  function automatic instr_t mem(input logic ld, input logic [31:0] rn, input logic [31:0] rm,
                                 input logic [11:0] off);
    instr_t i;
    i = blank();
    i.fmt = 2'b01; i.ld = ld; i.rn = rn; i.rm = rm; i.moff = off;
    return i;
  endfunction

  function automatic instr_t br(input logic [31:0] p, input logic bl, input logic [23:0] off);
    instr_t i;
    i = blank();
    i.fmt = 2'b10; i.pc = p; i.bl = bl; i.boff = off;
    return i;
  endfunction

  function automatic exp_t e_wb(input logic [3:0] r, input logic [31:0] v, input logic [3:0] f);
    exp_t e;
    e = '0; e.wb_en = 1'b1; e.wb_reg = r; e.wb_value = v; e.flags = f;
    return e;
  endfunction

  function automatic exp_t e_none(input logic [3:0] f);
    exp_t e;
    e = '0; e.flags = f;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic ld, input logic [31:0] a, input logic [31:0] sd,
                                 input logic [3:0] f);
    exp_t e;
    e = '0; e.mem_en = 1'b1; e.mem_is_load = ld; e.mem_addr = a; e.store = sd; e.flags = f;
    return e;
  endfunction

  task automatic apply(input instr_t i);
    pc = i.pc; condition = i.cond; format = i.fmt; opcode = i.opc;
    set_flags = i.s; is_immediate = i.imm; Rd = i.rd; Rn_value = i.rn;
    Rm_value = i.rm; operand = i.operand; is_load = i.ld; mem_offset = i.moff;
    branch_offset = i.boff; branch_link = i.bl;
  endtask

  // Present one instruction, wait for acceptance, then queue its expected slot.
  task automatic send(input string tag, input instr_t i, input exp_t e);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    apply(i);
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) sb.push_back(e);
    else check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Slot transfers downstream at the next posedge; compare it now.
  always @(negedge clk) begin
    if (chk_ready) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (out_valid && !out_ready) held_cnt++;
    end
    if (nreset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        got_e = sb.pop_front();
        check("wb_en", {31'd0, wb_en}, {31'd0, got_e.wb_en});
        if (got_e.wb_en) begin
          check("wb_reg", {28'd0, wb_reg}, {28'd0, got_e.wb_reg});
          check("wb_value", wb_value, got_e.wb_value);
        end
        check("mem_en", {31'd0, mem_en}, {31'd0, got_e.mem_en});
        if (got_e.mem_en) begin
          check("mem_is_load", {31'd0, mem_is_load}, {31'd0, got_e.mem_is_load});
          check("mem_addr", mem_addr, got_e.mem_addr);
          if (!got_e.mem_is_load) check("mem_store_data", mem_store_data, got_e.store);
        end
        check("branch_taken", {31'd0, branch_taken}, {31'd0, got_e.taken});
        if (got_e.taken) check("branch_target", branch_target, got_e.target);
        check("undef", {31'd0, undef}, {31'd0, got_e.undef});
        check("flags", {28'd0, flags}, {28'd0, got_e.flags});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    instr_t i;
    nreset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    apply(blank());
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_wb_value", wb_value, 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;

    // Reset while a result is held downstream.
    out_ready = 1'b0;
    send("adds_hold", dp(4'hE, 4'h4, 1'b1, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd0, 12'h001),
         e_wb(4'd3, 32'd0, 4'b0110));
    check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    check("hold_flags", {28'd0, flags}, 32'h6);
    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    nreset = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_flags", {28'd0, flags}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    nreset = 1'b1;
    out_ready = 1'b1;

    // SUBS to zero, then EQ / NE conditional moves.
    send("subs", dp(4'hE, 4'h2, 1'b1, 1'b1, 4'd0, 32'd5, 32'd0, 12'h005), e_wb(4'd0, 32'd0, 4'b0110));
    send("moveq", dp(4'h0, 4'hD, 1'b0, 1'b1, 4'd1, 32'd0, 32'd0, 12'h011), e_wb(4'd1, 32'h11, 4'b0110));
    send("movne", dp(4'h1, 4'hD, 1'b0, 1'b1, 4'd1, 32'd0, 32'd0, 12'h022), e_none(4'b0110));

    // Signed overflow on ADDS.
    send("adds_ovf", dp(4'hE, 4'h4, 1'b1, 1'b1, 4'd2, 32'h7FFF_FFFF, 32'd0, 12'h001),
         e_wb(4'd2, 32'h8000_0000, 4'b1001));

    // Rotated immediate 0xFF ror 8 sets N and C, keeps V.
    send("movs_rot", dp(4'hE, 4'hD, 1'b1, 1'b1, 4'd4, 32'd0, 32'd0, 12'h4FF),
         e_wb(4'd4, 32'hFF00_0000, 4'b1011));

    // Register shifter boundary encodings.
    send("lsr32", dp(4'hE, 4'hD, 1'b1, 1'b0, 4'd5, 32'd0, 32'h8000_0001, 12'h020),
         e_wb(4'd5, 32'd0, 4'b0111));
    send("asr32", dp(4'hE, 4'hD, 1'b1, 1'b0, 4'd5, 32'd0, 32'h8000_0000, 12'h040),
         e_wb(4'd5, 32'hFFFF_FFFF, 4'b1011));
    send("rrx", dp(4'hE, 4'hD, 1'b1, 1'b0, 4'd6, 32'd0, 32'h0000_0002, 12'h060),
         e_wb(4'd6, 32'h8000_0001, 4'b1001));
    send("lsl4", dp(4'hE, 4'hD, 1'b1, 1'b0, 4'd7, 32'd0, 32'hF000_0001, 12'h200),
         e_wb(4'd7, 32'h0000_0010, 4'b0011));

    // Carry-consuming ops and a compare without S.
    send("adc", dp(4'hE, 4'h5, 1'b0, 1'b1, 4'd8, 32'd10, 32'd0, 12'h005), e_wb(4'd8, 32'd16, 4'b0011));
    send("cmp", dp(4'hE, 4'hA, 1'b0, 1'b1, 4'd9, 32'd3, 32'd0, 12'h005), e_none(4'b1000));
    send("sbc", dp(4'hE, 4'h6, 1'b0, 1'b1, 4'd9, 32'd10, 32'd0, 12'h003), e_wb(4'd9, 32'd6, 4'b1000));
    send("movlt", dp(4'hB, 4'hD, 1'b0, 1'b1, 4'd2, 32'd0, 32'd0, 12'h007), e_wb(4'd2, 32'd7, 4'b1000));

    // Undefined format, passing and never conditions.
    i = blank(); i.fmt = 2'b11;
    e = e_none(4'b1000); e.undef = 1'b1;
    send("undef_al", i, e);
    i.cond = 4'hF;
    send("undef_nv", i, e_none(4'b1000));

    // Store with maximum offset.
    send("str", mem(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 12'hFFF),
         e_mem(1'b0, 32'h0000_1FFF, 32'hDEAD_BEEF, 4'b1000));

    // BL with negative offset, then a branch whose target wraps.
    e = e_wb(4'd14, 32'h0000_0104, 4'b1000); e.taken = 1'b1; e.target = 32'h0000_0100;
    send("bl", br(32'h0000_0100, 1'b1, 24'hFFFFFE), e);
    e = e_none(4'b1000); e.taken = 1'b1; e.target = 32'h0000_0000;
    send("b_wrap", br(32'hFFFF_FFF0, 1'b0, 24'h000002), e);

    // Stream of loads while downstream stalls intermittently.
    chk_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send("ldr_stream", mem(1'b1, 32'h0000_2000 + 32'(k * 16), 32'd0, 12'(k * 4)),
               e_mem(1'b1, 32'h0000_2000 + 32'(k * 20), 32'd0, 4'b1000));
      end
      begin
        logic [3:0] pat;
        pat = 4'b1101;
        for (int k = 0; k < 4; k++) begin
          out_ready = pat[k];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 50 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk_ready = 1'b0;
    check("stall_seen", {31'd0, (held_cnt != 0)}, 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
